regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised successor to the pipeline's 32x32 register file. It has NUM_RD async read
//  ports, two prioritised write ports (WB + late-load), a hardwired zero entry and a
//  sequential clear engine that zeroes one entry per cycle after reset or on soft clear.
//  It sits in ID (reads) and WB (writes); ready gates issue until the clear completes.
// PARAMETERS
//  DATA_W   32  word width in bits
//  DEPTH    32  number of entries incl. entry 0; power of 2, >=4
//  NUM_RD   2   number of read ports
//  ADDR_W   localparam = $clog2(DEPTH)
// PORTS
//  clk          in   1               single clock, all state updates on posedge
//  reset        in   1               synchronous, active-low (0 at posedge = reset)
//  clear_req    in   1               soft clear request, sampled only when ready=1
//  ready        out  1               1 = clear done, writes accepted
//  wr0_en       in   1               write port 0 enable (WB)
//  wr0_addr     in   ADDR_W          write port 0 address
//  wr0_data     in   DATA_W          write port 0 data
//  wr1_en       in   1               write port 1 enable (late-load), wins over port 0
//  wr1_addr     in   ADDR_W          write port 1 address
//  wr1_data     in   DATA_W          write port 1 data
//  rd_addr      in   NUM_RD*ADDR_W   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//  rd_data      out  NUM_RD*DATA_W   packed read data, port k at [k*DATA_W +: DATA_W]
//  wr_conflict  out  1               registered, 1-cycle pulse: both ports hit same nonzero addr
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state<=CLEAR, clr_idx<=1, ready<=0, wr_conflict<=0.
//    Storage is not touched in that cycle. Reset during CLEAR restarts at idx 1.
//  - FSM states: CLEAR, READY.
//    CLEAR: each cycle write 0 to entry clr_idx, then clr_idx++. When clr_idx==DEPTH-1 is
//    written, go to READY and set ready<=1. ready rises DEPTH-1 cycles after reset deasserts.
//    READY: clear_req=1 -> CLEAR, clr_idx<=1, ready<=0. Writes in that same cycle still commit.
//  - Writes are dropped while ready=0 and to address 0. Commit on posedge.
//    Both ports on the same address: wr1_data is stored and wr_conflict=1 on the next cycle.
//  - Reads are combinational. Address 0 always returns 0. While ready=0 every port returns 0.
//    A written value is visible on reads the cycle after the commit edge unless bypass is on.
//  - No arithmetic on data. clr_idx is ADDR_W bits and never wraps past DEPTH-1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined: same-cycle write->read forwarding. If rd_addr==wrN_addr with
//    wrN_en=1, ready=1 and the address nonzero, rd_data returns wrN_data (wr1 over wr0).
//  Undefined: reads return the stored value only. The pipeline forwarding unit covers WB->ID.
// STRUCTURE
//  regfile_pkg: state localparams (ST_CLEAR=1'b0, ST_READY=1'b1) and a clog2 helper.
//  Sub-module regfile_clear_fsm: owns state, clr_idx and ready, and outputs clr_we/clr_idx.
//  Top-level: storage array, write mux (clear > wr1 > wr0), read muxes, conflict flag.
// TESTING
//  1 Reset: reset=0 for 1 cycle, then 1 -> ready=0 for exactly 31 cycles, then 1.
//    All reads return 0 throughout.
//  2 Write then read: wr0 addr 5 = 32'hDEADBEEF -> rd port 0 addr 5 reads DEADBEEF next
//    cycle. A write to addr 0 -> reads 0.
//  3 Conflict: wr0 addr 7=32'h1111, wr1 addr 7=32'h2222 same cycle -> addr 7 reads 2222
//    and wr_conflict=1 for one cycle.
//  4 Soft clear: fill addr 3=32'hA5A5 then pulse clear_req -> ready=0 31 cycles, then
//    addr 3 reads 0. A write issued mid-clear is dropped.
//  5 Reset mid-clear: reset=0 at clr_idx=10 -> clear restarts and ready rises 31 cycles
//    after reset release.
//  6 Bypass: wr0 addr 9=32'h0F0F with rd addr 9 in the same cycle -> 0F0F with
//    REGFILE_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multiport register file slice.
//   - state_t : clear-engine states (ST_CLEAR = 1'b0, ST_READY = 1'b1)
//   - clog2() : ceiling log2, used to size address ports from DEPTH
//   Optional feature macro used by this slice: REGFILE_BYPASS_EN
// ---------------------------------------------------------------------------
package regfile_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_NUM_RD = 2;

  // Ceiling log2; clog2(1) == 0, clog2(32) == 5, clog2(33) == 6.
  function automatic int clog2(input int value);
    int result;
    int span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span * 2;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// ---------------------------------------------------------------------------
// regfile_clear_fsm
//   Sequential clear engine for the register file. After reset or a soft
//   clear request it walks entries 1..DEPTH-1, zeroing one per cycle, then
//   raises ready. Entry 0 is hardwired zero in the top and never visited.
//
// Ports
//   clk        in   1        clock, all updates on posedge
//   reset      in   1        synchronous, active-low
//   clear_req  in   1        soft clear request, honoured only while ready=1
//   ready      out  1        1 = clear finished, normal writes allowed
//   clr_we     out  1        zero-write strobe for entry clr_idx this cycle
//   clr_idx    out  ADDR_W   entry being zeroed
//
// Macros: none (REGFILE_BYPASS_EN only affects the top level).
// ---------------------------------------------------------------------------
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              ready,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_idx
);

  localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] idx_nxt;
  logic              ready_nxt;

  // State register. Reset leaves storage alone and restarts the walk at 1,
  // even if a clear was already in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= ST_CLEAR;
      clr_idx <= FIRST_IDX;
      ready   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_idx <= idx_nxt;
      ready   <= ready_nxt;
    end
  end

  // Next-state logic. The index saturates at DEPTH-1 so it never wraps
  // back onto entry 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = clr_idx;
    ready_nxt = ready;
    clr_we    = 1'b0;
    case (state)
      ST_CLEAR: begin
        // The reset cycle itself must not write storage.
        clr_we = reset;
        if (clr_idx == LAST_IDX) begin
          state_nxt = ST_READY;
          ready_nxt = 1'b1;
        end else begin
          idx_nxt = clr_idx + FIRST_IDX;
        end
      end
      ST_READY: begin
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = FIRST_IDX;
          ready_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = FIRST_IDX;
        ready_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_multiport.sv
// ---------------------------------------------------------------------------
// regfile_multiport
//   Parametrised register file: NUM_RD combinational read ports, two write
//   ports (wr1 late-load beats wr0 writeback), entry 0 hardwired to zero,
//   and a sequential clear engine that gates issue through ready.
//
// Ports
//   clk          in   1               clock
//   reset        in   1               synchronous, active-low
//   clear_req    in   1               soft clear request (sampled when ready=1)
//   ready        out  1               1 = clear done, writes accepted
//   wr0_en/addr/data  in              write port 0 (WB)
//   wr1_en/addr/data  in              write port 1 (late-load), higher priority
//   rd_addr      in   NUM_RD*ADDR_W   port k at [k*ADDR_W +: ADDR_W]
//   rd_data      out  NUM_RD*DATA_W   port k at [k*DATA_W +: DATA_W]
//   wr_conflict  out  1               registered pulse: both ports wrote the
//                                     same nonzero address last cycle
//
// Macro REGFILE_BYPASS_EN: when defined, reads forward same-cycle write data
//   (wr1 over wr0). When undefined, reads return stored contents only.
// ---------------------------------------------------------------------------
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  parameter  int NUM_RD = DEFAULT_NUM_RD,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_req,
  output logic                     ready,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic              wr0_hit;
  logic              wr1_hit;

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk       (clk),
    .reset     (reset),
    .clear_req (clear_req),
    .ready     (ready),
    .clr_we    (clr_we),
    .clr_idx   (clr_idx)
  );

  // Writes need ready=1 and no reset in the same cycle; entry 0 is never stored.
  assign wr_ok   = ready && reset;
  assign wr0_hit = wr0_en && (wr0_addr != '0);
  assign wr1_hit = wr1_en && (wr1_addr != '0);

  // Storage write. wr1 is issued after wr0 so on an address collision its
  // non-blocking update lands last and wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      if (wr0_hit) begin
        mem[wr0_addr] <= wr0_data;
      end
      if (wr1_hit) begin
        mem[wr1_addr] <= wr1_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_conflict <= 1'b0;
    end else begin
      wr_conflict <= wr_ok && wr0_hit && wr1_hit && (wr0_addr == wr1_addr);
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] word;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      word = '0;
      if (ready && (addr != '0)) begin
        word = mem[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr0_en && (wr0_addr == addr)) begin
          word = wr0_data;
        end
        if (wr1_en && (wr1_addr == addr)) begin
          word = wr1_data;
        end
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = word;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// ---------------------------------------------------------------------------
// tb_regfile_multiport
//   Self-checking bench for regfile_multiport. A behavioural model tracks
//   ready as a countdown of remaining clear cycles and zeroes its whole
//   array the moment the clear finishes; every compare is against it or a
//   fixed constant. Define REGFILE_BYPASS_EN for both bench and RTL to
//   exercise forwarding.
// ---------------------------------------------------------------------------
module tb_regfile_multiport;

  localparam int DW     = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 2;
  localparam int AW     = 5;

  logic               clk;
  logic               reset;
  logic               clear_req;
  logic               ready;
  logic               wr0_en;
  logic [AW-1:0]      wr0_addr;
  logic [DW-1:0]      wr0_data;
  logic               wr1_en;
  logic [AW-1:0]      wr1_addr;
  logic [DW-1:0]      wr1_data;
  logic [NUM_RD*AW-1:0] rd_addr;
  logic [NUM_RD*DW-1:0] rd_data;
  logic               wr_conflict;

  int vectors;
  int miscompares;

  // Behavioural model state.
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_ready;
  logic          m_conf;
  int            m_left;

  regfile_multiport #(
    .DATA_W (DW),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear_req   (clear_req),
    .ready       (ready),
    .wr0_en      (wr0_en),
    .wr0_addr    (wr0_addr),
    .wr0_data    (wr0_data),
    .wr1_en      (wr1_en),
    .wr1_addr    (wr1_addr),
    .wr1_data    (wr1_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .wr_conflict (wr_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for one port given the current inputs.
  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (!m_ready || a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr1_en && wr1_addr == a) return wr1_data;
    if (wr0_en && wr0_addr == a) return wr0_data;
`endif
    return m_mem[a];
  endfunction

  // Advance the model by one clock edge using the inputs held at that edge.
  task automatic model_update();
    if (!reset) begin
      m_left  = DEPTH - 1;
      m_ready = 1'b0;
      m_conf  = 1'b0;
    end else if (!m_ready) begin
      m_conf = 1'b0;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
    end else begin
      m_conf = wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != '0;
      if (wr0_en && wr0_addr != '0) m_mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != '0) m_mem[wr1_addr] = wr1_data;
      if (clear_req) begin
        m_ready = 1'b0;
        m_left  = DEPTH - 1;
      end
    end
  endtask

  // Clock edge, model update, then back to the negedge for driving.
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear_req = 1'b0;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    wr0_addr  = '0;
    wr1_addr  = '0;
    wr0_data  = '0;
    wr1_data  = '0;
  endtask

  task automatic set_rd(input int port, input logic [AW-1:0] a);
    rd_addr[port*AW +: AW] = a;
  endtask

  // Count cycles ready stays low after the current point, checking that
  // all read ports stay zero meanwhile.
  task automatic test_reset();
    int low_cycles;
    $display("[TB] test_reset");
    idle_inputs();
    reset = 1'b0;
    step();
    reset = 1'b1;
    low_cycles = 0;
    for (int c = 0; c < 100 && ready !== 1'b1; c++) begin
      set_rd(0, AW'($urandom_range(0, DEPTH - 1)));
      set_rd(1, AW'($urandom_range(0, DEPTH - 1)));
      #1;
      for (int k = 0; k < NUM_RD; k++) begin
        vectors++;
        if (rd_data[k*DW +: DW] !== '0) begin
          miscompares++;
          $display("[TB] FAIL reset_rd%0d: got %h expected 0", k, rd_data[k*DW +: DW]);
        end
      end
      low_cycles++;
      step();
    end
    vectors++;
    if (low_cycles !== DEPTH - 1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_low: got %0d cycles expected %0d", low_cycles, DEPTH - 1);
    end
    vectors++;
    if (ready !== 1'b1 || m_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_ready_high: got %b expected 1", ready);
    end
  endtask

  task automatic test_write_read();
    $display("[TB] test_write_read");
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd5; wr0_data = 32'hDEADBEEF;
    step();
    idle_inputs();
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_addr5: got %h expected deadbeef", rd_data[0 +: DW]);
    end
    vectors++;
    if (rd_data[DW +: DW] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_addr6: got %h expected 0", rd_data[DW +: DW]);
    end
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hCAFEF00D;
    step();
    idle_inputs();
    set_rd(0, 5'd0);
    set_rd(1, 5'd5);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_addr0: got %h expected 0", rd_data[0 +: DW]);
    end
    vectors++;
    if (rd_data[DW +: DW] !== 32'hDEADBEEF) begin
      miscompares++;
      $display("[TB] FAIL wr_rd_port1: got %h expected deadbeef", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_conflict();
    $display("[TB] test_conflict");
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd7; wr0_data = 32'h1111;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'h2222;
    step();
    idle_inputs();
    set_rd(0, 5'd7);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h2222) begin
      miscompares++;
      $display("[TB] FAIL conflict_data: got %h expected 2222", rd_data[0 +: DW]);
    end
    vectors++;
    if (wr_conflict !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL conflict_flag: got %b expected 1", wr_conflict);
    end
    step();
    #1;
    vectors++;
    if (wr_conflict !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL conflict_pulse: got %b expected 0", wr_conflict);
    end
  endtask

  task automatic test_soft_clear();
    int low_cycles;
    $display("[TB] test_soft_clear");
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'hA5A5;
    step();
    idle_inputs();
    set_rd(0, 5'd3);
    set_rd(1, 5'd12);
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'hA5A5) begin
      miscompares++;
      $display("[TB] FAIL clear_prefill: got %h expected a5a5", rd_data[0 +: DW]);
    end
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    low_cycles = 0;
    for (int c = 0; c < 100 && ready !== 1'b1; c++) begin
      if (c == 5) begin
        wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h1234;
      end else begin
        wr0_en = 1'b0;
      end
      #1;
      vectors++;
      if (rd_data[0 +: DW] !== '0) begin
        miscompares++;
        $display("[TB] FAIL clear_rd_busy: got %h expected 0", rd_data[0 +: DW]);
      end
      low_cycles++;
      step();
    end
    idle_inputs();
    vectors++;
    if (low_cycles !== DEPTH - 1) begin
      miscompares++;
      $display("[TB] FAIL clear_ready_low: got %0d cycles expected %0d", low_cycles, DEPTH - 1);
    end
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL clear_addr3: got %h expected 0", rd_data[0 +: DW]);
    end
    vectors++;
    if (rd_data[DW +: DW] !== 32'h0) begin
      miscompares++;
      $display("[TB] FAIL clear_dropped_wr: got %h expected 0", rd_data[DW +: DW]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int low_cycles;
    $display("[TB] test_reset_mid_clear");
    idle_inputs();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    // After the request edge the engine sits at index 1; nine more edges reach 10.
    for (int c = 0; c < 9; c++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    low_cycles = 0;
    for (int c = 0; c < 100 && ready !== 1'b1; c++) begin
      low_cycles++;
      step();
    end
    vectors++;
    if (low_cycles !== DEPTH - 1) begin
      miscompares++;
      $display("[TB] FAIL midclr_ready_low: got %0d cycles expected %0d", low_cycles, DEPTH - 1);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] exp_same;
    $display("[TB] test_bypass");
    idle_inputs();
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h1234;
    step();
    wr0_data = 32'h0F0F;
    set_rd(0, 5'd9);
    set_rd(1, 5'd0);
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h0F0F;
`else
    exp_same = 32'h1234;
`endif
    vectors++;
    if (rd_data[0 +: DW] !== exp_same) begin
      miscompares++;
      $display("[TB] FAIL bypass_same_cycle: got %h expected %h", rd_data[0 +: DW], exp_same);
    end
    step();
    idle_inputs();
    #1;
    vectors++;
    if (rd_data[0 +: DW] !== 32'h0F0F) begin
      miscompares++;
      $display("[TB] FAIL bypass_after: got %h expected 0f0f", rd_data[0 +: DW]);
    end
  endtask

  // Random traffic on a narrow address window to provoke collisions, with
  // occasional soft clears and resets.
  task automatic test_random();
    logic [AW-1:0] a;
    $display("[TB] test_random");
    for (int c = 0; c < 600; c++) begin
      reset     = ($urandom_range(0, 149) != 0);
      clear_req = ($urandom_range(0, 79) == 0);
      wr0_en    = $urandom_range(0, 1) == 1;
      wr1_en    = $urandom_range(0, 2) == 0;
      wr0_addr  = AW'($urandom_range(0, 7));
      wr1_addr  = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH - 1))
                                              : AW'($urandom_range(0, 7));
      wr0_data  = $urandom;
      wr1_data  = $urandom;
      for (int k = 0; k < NUM_RD; k++) begin
        if ($urandom_range(0, 2) == 0) set_rd(k, $urandom_range(0, 1) == 1 ? wr0_addr : wr1_addr);
        else set_rd(k, AW'($urandom_range(0, 7)));
      end
      #1;
      vectors++;
      if (ready !== m_ready) begin
        miscompares++;
        $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, ready, m_ready);
      end
      vectors++;
      if (wr_conflict !== m_conf) begin
        miscompares++;
        $display("[TB] FAIL rand_conflict c=%0d: got %b expected %b", c, wr_conflict, m_conf);
      end
      for (int k = 0; k < NUM_RD; k++) begin
        a = rd_addr[k*AW +: AW];
        vectors++;
        if (rd_data[k*DW +: DW] !== model_rd(a)) begin
          miscompares++;
          $display("[TB] FAIL rand_rd%0d c=%0d addr=%0d: got %h expected %h",
                   k, c, a, rd_data[k*DW +: DW], model_rd(a));
        end
      end
      step();
    end
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ready     = 1'b0;
    m_conf      = 1'b0;
    m_left      = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    reset   = 1'b0;
    rd_addr = '0;
    idle_inputs();
    @(negedge clk);

    test_reset();
    test_write_read();
    test_conflict();
    test_soft_clear();
    test_reset_mid_clear();
    test_bypass();
    test_random();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
